// File: rtl/score_watch_pkg.sv
// Shared game-map constants and types for the RAM score watchers.
package score_watch_pkg;

  localparam logic [15:0] SCORE_P1_ADDR = 16'hBDE4;
  localparam int          SCORE_BYTES   = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } settle_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
  } cpu_wr_t;

endpackage

// File: rtl/settle_timer.sv
// Restartable quiet-period timer: expire fires once SETTLE_CYCLES clocks pass with no kick.
module settle_timer
  import score_watch_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic active,
  output logic expire
);

  localparam int             CW   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  settle_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A kick in the would-expire cycle wins and restarts the quiet period.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (kick) begin
          state_nx = SETTLING;
          cnt_nx   = '0;
        end
      end
      SETTLING: begin
        if (kick) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          expire   = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign active = (state == SETTLING);

endmodule

// File: rtl/score_watch.sv
// Snoops CPU writes to the P1 score bytes and publishes a coherent 32-bit score once the burst settles.
module score_watch
  import score_watch_pkg::*;
#(
  parameter logic [15:0] SCORE_ADDR    = SCORE_P1_ADDR,
  parameter int          SETTLE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_we,
  output logic [31:0] score_p1,
  output logic        event_score_change
);

  cpu_wr_t                        wr;
  logic [15:0]                    offset;
  logic                           hit;
  logic [SCORE_BYTES-1:0]         byte_hit;
  logic [SCORE_BYTES-1:0]         byte_diff;
  logic [SCORE_BYTES-1:0][7:0]    shadow;
  logic                           dirty;
  logic                           tmr_active;
  logic                           tmr_expire;

  assign wr     = '{addr: cpu_addr, data: cpu_data, we: cpu_we};
  assign offset = wr.addr - SCORE_ADDR;
  // The >= guard stops addresses below SCORE_ADDR from aliasing in via 16-bit wrap.
  assign hit    = wr.we && (wr.addr >= SCORE_ADDR) && (offset < 16'(SCORE_BYTES));

  // Lowest address is the MSB, so shadow[SCORE_BYTES-1] maps to offset 0.
  for (genvar b = 0; b < SCORE_BYTES; b++) begin : g_byte
    assign byte_hit[b]  = hit && (offset[1:0] == 2'(SCORE_BYTES - 1 - b));
    assign byte_diff[b] = byte_hit[b] && (wr.data != shadow[b]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      for (int b = 0; b < SCORE_BYTES; b++)
        if (byte_hit[b]) shadow[b] <= wr.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty              <= 1'b0;
      score_p1           <= '0;
      event_score_change <= 1'b0;
    end else begin
      event_score_change <= 1'b0;
      if (|byte_diff) begin
        dirty <= 1'b1;
      end else if (tmr_expire && tmr_active) begin
        dirty <= 1'b0;
        if (dirty) begin
          score_p1           <= shadow;
          event_score_change <= 1'b1;
        end
      end
    end
  end

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .kick   (hit),
    .active (tmr_active),
    .expire (tmr_expire)
  );

endmodule

// File: doc/score_watch.md
Name: score_watch

Overview:
- Bus-snooping stage directly upstream of `events`; produces its `score_p1` and `event_score_change` inputs.
- Watches CPU writes to the four player-1 score bytes in RAM (BCD, MSB first).
- The game writes a score update one byte per write cycle. The block shadows those bytes, waits for the write burst to go quiet, then publishes one coherent 32-bit score with a single-cycle change pulse.

Parameters:
- SCORE_ADDR, 16'hBDE4, address of the MSB of the P1 score; bytes occupy SCORE_ADDR..SCORE_ADDR+3.
- SETTLE_CYCLES, 1000, quiet clocks required after the last score-byte write before publishing; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- cpu_addr  input  16  CPU address bus, sampled when cpu_we=1.
- cpu_data  input  8  CPU write data, sampled when cpu_we=1.
- cpu_we  input  1  single-cycle write strobe, one per CPU write.
- score_p1  output  32  last published score; byte 3 (bits 31:24) = SCORE_ADDR+0 … byte 0 = SCORE_ADDR+3.
- event_score_change  output  1  one-clock pulse, asserted in the cycle score_p1 first shows a new value.

Behaviour:
- Reset (rst=1 on a clock edge):
  - score_p1=0, event_score_change=0.
  - Shadow bytes=0, dirty=0, settle counter=0, state=IDLE.
  - Applies at any time, including mid-SETTLING; no pulse is emitted for a settle aborted by reset.
- Hit:
  - cpu_we=1 and cpu_addr in [SCORE_ADDR, SCORE_ADDR+3].
  - Byte index = cpu_addr-SCORE_ADDR. Compare uses a 16-bit subtract with no wrap across 16'hFFFF (unsigned range check).
- On a hit:
  - The shadow byte takes cpu_data.
  - dirty sets if cpu_data differs from the current shadow byte. Same-value writes do not set dirty but still count as activity.
- State machine: IDLE, SETTLING.
  - IDLE: a hit moves to SETTLING and the counter loads 0.
  - SETTLING, hit this cycle: the counter reloads 0 and the state stays SETTLING. A hit takes priority over expiry in the same cycle.
  - SETTLING, no hit, counter < SETTLE_CYCLES-1: the counter increments.
  - SETTLING, no hit, counter == SETTLE_CYCLES-1: expiry.
    - If dirty: score_p1 takes the shadow (registered), event_score_change=1 for exactly that cycle, dirty clears.
    - If not dirty: no pulse, score_p1 is unchanged.
    - Either way the state returns to IDLE.
- Latency: the pulse and the new score_p1 appear SETTLE_CYCLES clocks after the edge on which the last hit was sampled. Example: last hit at edge N, SETTLE_CYCLES=4 → pulse visible after edge N+4.
- score_p1 never changes outside an expiry, so the downstream stage always sees a consistent 4-byte value.
- Shadow register: dirty compares against the shadow, not against score_p1.
  - A burst that changes a byte and then restores its original value still pulses, publishing the unchanged value.
  - This is intentional; it keeps the logic simple and is harmless downstream.
- Non-hit writes, and reads (cpu_we=0), are ignored entirely and do not restart the counter.
- Counter width: $clog2(SETTLE_CYCLES+1) bits; it never wraps because it is reloaded or stopped before overflow.
- BCD validity is not checked; bytes pass through verbatim.
- event_score_change is registered, never combinational; it is never high in two consecutive cycles.

Decomposition:
- Shared package (events/game-map constants):
  - SCORE_P1_ADDR (16'hBDE4) and score byte count 4, reusable by the future P2 watcher.
  - State encoding localparams: IDLE=1'b0, SETTLING=1'b1.
- One natural sub-module: `settle_timer`, a restartable quiet-period counter.
  - Inputs: rst, clk, kick.
  - Outputs: active, expire (one-cycle).
  - Parameter: SETTLE_CYCLES.
  - Reused later for other multi-byte RAM watchers.
- Byte capture, dirty tracking and publish logic stay in score_watch.

Test Plan (SETTLE_CYCLES=4, SCORE_ADDR=16'hBDE4):
- Reset mid-SETTLING: hit BDE7=0x99, assert rst after 2 clocks → score_p1=0, no pulse ever; a later 4-write burst publishes normally.
- Basic burst: writes 12,34,56,78 to BDE4..BDE7 on consecutive cycles → exactly one pulse, 4 clocks after the 0x78 write; score_p1=32'h12345678 on that cycle and held afterwards.
- Restart: write BDE7=0x10, idle 3 clocks, write BDE6=0x20, idle → single pulse 4 clocks after the second write; score_p1=32'h00002010; no pulse after the first write.
- Same-value write: after the basic burst, write BDE5=0x34 → no pulse, score_p1 unchanged at 32'h12345678.
- Boundary addresses: writes to BDE3 and BDE8 with data 0xFF, plus reads of BDE4 (cpu_we=0) → no shadow change, no pulse, counter not restarted during an active settle.
- Hit on expiry cycle: hit BDE4=0x01, then hit BDE4=0x02 exactly on the would-expire clock → no pulse there; one pulse 4 clocks later with score_p1[31:24]=8'h02.
